// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment display scheduler.
package seg_pkg;
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CONV, S_DONE} seg_state_t;

  localparam logic [3:0] DIGIT_DASH = 4'd10;

  // Segment codes {a..g}, active-low
  localparam logic [6:0] SEG_0    = 7'b0000001;
  localparam logic [6:0] SEG_1    = 7'b1001111;
  localparam logic [6:0] SEG_2    = 7'b0010010;
  localparam logic [6:0] SEG_3    = 7'b0000110;
  localparam logic [6:0] SEG_4    = 7'b1001100;
  localparam logic [6:0] SEG_5    = 7'b0100100;
  localparam logic [6:0] SEG_6    = 7'b0100000;
  localparam logic [6:0] SEG_7    = 7'b0001111;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0000100;
  localparam logic [6:0] SEG_DASH = 7'b1111110;

  localparam logic [3:0] AN_THOU = 4'b0111;
  localparam logic [3:0] AN_HUND = 4'b1011;
  localparam logic [3:0] AN_TENS = 4'b1101;
  localparam logic [3:0] AN_ONES = 4'b1110;

  function automatic logic [6:0] seg_decode(logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_DASH;
    endcase
  endfunction
endpackage

// File: rtl/seg_display_sched_if.sv
// Requester-side and pin-side signals of the display scheduler.
interface seg_display_sched_if #(parameter int N_SRC = 4);
  logic [8*N_SRC-1:0] src_data;
  logic [N_SRC-1:0]   src_valid;
  logic               signed_mode;
  logic               hold;
  logic               next;
  logic [1:0]         cur_src;
  logic [3:0]         Anode;
  logic [6:0]         LED_out;

  modport master (output src_data, src_valid, signed_mode, hold, next,
                  input  cur_src, Anode, LED_out);
  modport slave  (input  src_data, src_valid, signed_mode, hold, next,
                  output cur_src, Anode, LED_out);
endinterface

// File: rtl/bcd_seq_conv.sv
// Iterative double-dabble: 9-bit magnitude to three BCD nibbles in 8 cycles.
module bcd_seq_conv (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [8:0] mag,
  output logic       busy,
  output logic       done,
  output logic [3:0] hund,
  output logic [3:0] tens,
  output logic [3:0] ones
);
  logic [11:0] bcd_q, bcd_d, adj;
  logic [7:0]  sh_q, sh_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;

  function automatic logic [3:0] add3(logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  always_comb begin
    bcd_d  = bcd_q;
    sh_d   = sh_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    adj    = {add3(bcd_q[11:8]), add3(bcd_q[7:4]), add3(bcd_q[3:0])};
    if (start) begin
      // bit 8 is pre-shifted so the 8 iterations consume bits 7..0
      bcd_d  = {11'b0, mag[8]};
      sh_d   = mag[7:0];
      cnt_d  = 3'd0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      bcd_d = (adj << 1) | {11'b0, sh_q[7]};
      sh_d  = {sh_q[6:0], 1'b0};
      cnt_d = cnt_q + 3'd1;
      if (cnt_q == 3'd7) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_q  <= '0;
      sh_q   <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      bcd_q  <= bcd_d;
      sh_q   <= sh_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;
  assign done = busy_q && (cnt_q == 3'd7);
  assign hund = bcd_q[11:8];
  assign tens = bcd_q[7:4];
  assign ones = bcd_q[3:0];
endmodule

// File: rtl/seg_display_sched.sv
// Round-robin requester scheduler, BCD sequencing and 4-digit anode scan.
module seg_display_sched
  import seg_pkg::*;
#(
  parameter int N_SRC        = 4,
  parameter int DWELL_CYCLES = 100_000_000,
  parameter int SCAN_BITS    = 20
) (
  input logic clk,
  input logic rst_n,
  seg_display_sched_if.slave bus
);
  localparam int DW = $clog2(DWELL_CYCLES);

  seg_state_t           state_q, state_d;
  logic [1:0]           ptr_q, ptr_d, nxt_ptr, sel_ptr, cand;
  logic [DW-1:0]        dwell_q, dwell_d;
  logic [SCAN_BITS-1:0] scan_q, scan_d;
  logic                 pend_q, pend_d, neg_q, neg_d, none_q, none_d;
  logic [3:0][3:0]      dig_q, dig_d;
  logic                 trig, found, start, neg_now;
  logic [3:0]           valid4;
  logic [31:0]          data_w;
  logic [7:0]           sel_data;
  logic [8:0]           mag;
  logic                 conv_busy, conv_done;
  logic [3:0]           c_hund, c_tens, c_ones;
  logic [1:0]           sel;

  assign valid4 = 4'(bus.src_valid);
  assign data_w = 32'(bus.src_data);

  // next valid requester searching upward; stays put when none is valid
  always_comb begin
    nxt_ptr = ptr_q;
    found   = 1'b0;
    cand    = '0;
    for (int i = 1; i <= N_SRC; i++) begin
      cand = 2'((int'(ptr_q) + i) % N_SRC);
      if (!found && valid4[cand]) begin
        nxt_ptr = cand;
        found   = 1'b1;
      end
    end
  end

  assign sel_ptr  = pend_q ? nxt_ptr : ptr_q;
  assign sel_data = data_w[{sel_ptr, 3'b000} +: 8];
  assign neg_now  = bus.signed_mode && sel_data[7];
  assign mag      = neg_now ? (9'd256 - {1'b0, sel_data}) : {1'b0, sel_data};
  assign start    = (state_q == S_LOAD);

  always_comb begin
    trig    = 1'b0;
    dwell_d = dwell_q + 1'b1;
    if (bus.hold) begin
      dwell_d = '0;
    end else if (dwell_q == DW'(DWELL_CYCLES - 1)) begin
      dwell_d = '0;
      trig    = 1'b1;
    end
    // a trigger in the LOAD cycle survives the clear and waits for the next loop
    pend_d = pend_q;
    if (state_q == S_LOAD) pend_d = 1'b0;
    if (trig || bus.next)  pend_d = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    neg_d   = neg_q;
    none_d  = none_q;
    dig_d   = dig_q;
    case (state_q)
      S_IDLE: state_d = S_LOAD;
      S_LOAD: begin
        ptr_d   = sel_ptr;
        neg_d   = neg_now;
        none_d  = ~|bus.src_valid;
        state_d = S_CONV;
      end
      S_CONV: begin
        if (conv_done)      state_d = S_DONE;
        else if (!conv_busy) state_d = S_LOAD;
      end
      S_DONE: begin
        if (none_q) dig_d = {4{DIGIT_DASH}};
        else        dig_d = {neg_q ? DIGIT_DASH : 4'd0, c_hund, c_tens, c_ones};
        state_d = S_LOAD;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign scan_d = scan_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      dwell_q <= '0;
      scan_q  <= '0;
      pend_q  <= 1'b0;
      neg_q   <= 1'b0;
      none_q  <= 1'b0;
      dig_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      dwell_q <= dwell_d;
      scan_q  <= scan_d;
      pend_q  <= pend_d;
      neg_q   <= neg_d;
      none_q  <= none_d;
      dig_q   <= dig_d;
    end
  end

  bcd_seq_conv u_conv (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .mag   (mag),
    .busy  (conv_busy),
    .done  (conv_done),
    .hund  (c_hund),
    .tens  (c_tens),
    .ones  (c_ones)
  );

  assign sel = scan_q[SCAN_BITS-1 -: 2];

  always_comb begin
    bus.Anode   = AN_THOU;
    bus.LED_out = seg_decode(dig_q[3]);
    case (sel)
      2'b01: begin bus.Anode = AN_HUND; bus.LED_out = seg_decode(dig_q[2]); end
      2'b10: begin bus.Anode = AN_TENS; bus.LED_out = seg_decode(dig_q[1]); end
      2'b11: begin bus.Anode = AN_ONES; bus.LED_out = seg_decode(dig_q[0]); end
      default: ;
    endcase
  end

  assign bus.cur_src = ptr_q;
endmodule

// File: doc/seg_display_sched.md
# seg_display_sched

Scheduler and sequencer for the board's 4-digit seven-segment display. It shares the display among up to four 8-bit requesters (PC low byte, ALU result, register read port, debug value). Requesters are visited round-robin with a programmable dwell time. Each selected value goes through an iterative, multi-cycle binary-to-BCD converter, is latched into digit registers, and is scanned onto the multiplexed anodes. It sits between the CPU debug taps and the board pins.

## Interface
- `N_SRC`, 4, number of requesters (1..4)
- `DWELL_CYCLES`, 100_000_000, clock cycles each requester stays on the display (>= 16)
- `SCAN_BITS`, 20, refresh counter width; the top 2 bits select the digit
- `clk`  in  1  system clock; all state is on its rising edge
- `rst_n`  in  1  reset; asynchronous and active-low
- `src_data`  in  8*N_SRC  requester values; requester k occupies bits [8k+7:8k]
- `src_valid`  in  N_SRC  requester k may be displayed while its bit is high
- `signed_mode`  in  1  1: treat data as two's complement
- `hold`  in  1  freeze on the current requester; the dwell counter is held at 0
- `next`  in  1  single-cycle pulse; advance to the next requester at the next LOAD
- `cur_src`  out  2  index of the requester currently displayed
- `Anode`  out  4  digit enables, active-low; `4'b0111` selects the thousands digit
- `LED_out`  out  7  segments {a..g}, active-low

## Operation
- FSM states: IDLE -> LOAD -> CONV -> DONE -> LOAD, looping continuously so that live values update.
- **IDLE**: entered only from reset. Leaves on the next cycle.
- **LOAD**: applies any pending advance to the pointer. Samples the selected requester's data, computes the magnitude and sign, and clears the BCD shift registers.
- **Pointer advance**: the pointer goes to the next index with `src_valid` set, searching upward mod `N_SRC`.
  - If no bit of `src_valid` is set, the pointer is unchanged.
  - If no bit of `src_valid` is set, DONE latches DASH (code 10) into all four digits.
- **Magnitude**:
  - When `signed_mode` is 1 and bit 7 is set, magnitude = two's-complement negation, 9 bits wide, so -128 gives 128.
  - Otherwise magnitude = data, with no sign.
- **CONV**: exactly 8 iterations, one per cycle, shift-add-3 double-dabble over the hundreds, tens and ones nibbles.
  - In each iteration, every nibble >= 5 first gets +3, then the whole register shifts left by one, taking the next magnitude bit MSB-first.
  - The 9th magnitude bit is loaded before the first iteration, so 128 converts correctly.
- **DONE**: latches the hundreds, tens and ones digits. The thousands digit is DASH when the value is negative, otherwise 0.
- **Pending advance** is set by either:
  - the dwell counter reaching `DWELL_CYCLES-1` while `hold` is 0, after which the counter wraps to 0;
  - a `next` pulse, which is honoured even when `hold` is 1.
  - Multiple triggers before the next LOAD collapse into a single advance.
- **Scan**: the free-running refresh counter's top bits select the digit: 00 thousands, 01 hundreds, 10 tens, 11 ones. Anode codes in that order are 0111, 1011, 1101, 1110.
- **Segment codes**, digits 0..9: 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 0100000, 0001111, 0000000, 0000100. DASH is 1111110.

## Timing
- **Reset values**:
  - FSM = IDLE; pointer, dwell counter and refresh counter = 0; all digit registers = 0; pending = 0.
  - Outputs: `cur_src` = 0, `Anode` = 4'b0111, `LED_out` = 7'b0000001.
- **Latency**: the value sampled in LOAD appears in the digit registers on the cycle after DONE. That is 10 cycles from LOAD (1 LOAD + 8 CONV + 1 DONE), and a full loop is 10 cycles.
- **`cur_src`** updates in the LOAD cycle that applies the advance. The digits continue to show the previous requester until the following DONE; there is no blank frame.
- **Input changes**: `src_data` is sampled only in LOAD. Changes during CONV are ignored until the next loop.
- **`src_valid` deasserting** for the current requester does not force an immediate switch. It takes effect at the next advance.
- **Reset asserted mid-CONV** returns immediately to reset values. Partial BCD results are never latched.
- **`Anode` and `LED_out`** are combinational from the registered refresh counter bits and the digit registers, with no extra pipeline stage.

## Structure
- Shared package `seg_pkg` holds:
  - the FSM state enum `seg_state_t`;
  - digit code constant `DIGIT_DASH` = 4'd10;
  - the 11 segment-code constants, and the anode constants.
- Sub-module `bcd_seq_conv` holds the LOAD/CONV datapath only: 9-bit magnitude in, `start`, `busy`, `done` pulse, and three BCD nibbles out. The scheduler owns the FSM sequencing, pointer, dwell counter and scan.

## Test plan
- **Single requester**: `N_SRC`=1, data=8'd255, `signed_mode`=0 -> digits 0,2,5,5 within 11 cycles of reset release. Scanning `Anode` 0111 shows `LED_out` 0000001 (0); 1110 shows 0100100 (5).
- **Signed extremes**: data=8'h80, `signed_mode`=1 -> digits DASH,1,2,8. Data=8'hFF -> DASH,0,0,1. Same 8'h80 with `signed_mode`=0 -> 0,1,2,8.
- **Round-robin with a hole**:
  - Stimulus: `DWELL_CYCLES`=16, `src_valid`=4'b1011, data 10/20/30/40.
  - Required: `cur_src` sequence 0,1,3,0; requester 2 is never shown.
  - Required: each switch lands within 26 cycles of the prior one.
- **`hold` and `next`**: with `hold`=1, `cur_src` is stable for 200 cycles. A single `next` pulse advances `cur_src` exactly once, at the next LOAD. Two pulses 3 cycles apart advance it once.
- **No valid requester**: `src_valid`=0 -> all four digits read DASH (`LED_out`=1111110) after one loop, and `cur_src` is unchanged.
- **Reset mid-conversion**: assert `rst_n` low 4 cycles after LOAD with data=8'd99 -> outputs return to their reset values asynchronously. After release, the digits read 0,0,9,9 with no stale partial value.
